// File: rtl/first_counter_pkg.sv
// first_counter_pkg: shared FSM state encoding and default width for the first_* up/down counters
package first_counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/first_prescaler.sv
// first_prescaler: divides enabled cycles by PRESCALE into one-cycle ticks; ports clk reset(async low) en clr -> tick
module first_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/first_down_counter.sv
// first_down_counter: loadable down-counter/timer with sticky+pulsed underflow, stop or auto-reload; ports clk reset(async low) load load_value enable auto_reload underflow_clr -> counter_out underflow_out underflow_pulse busy; FIRST_DOWN_COUNTER_PRESCALE_EN enables the PRESCALE tick divider
module first_down_counter
  import first_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             underflow_clr,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             underflow_pulse,
  output logic             busy
);
  state_t state, state_next;
  logic [WIDTH-1:0] reload, count_next;
  logic run_en, tick, uf;
  if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
    $error("first_down_counter: WIDTH or PRESCALE out of range");
  end
  assign run_en = enable && state == RUN && !load;
`ifdef FIRST_DOWN_COUNTER_PRESCALE_EN
  first_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (run_en),
    .clr  (load || state != RUN),
    .tick (tick)
  );
`else
  assign tick = run_en;
`endif
  assign uf = tick && counter_out == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = load ? RUN : (uf && !auto_reload) ? DONE : state;
    count_next = load ? load_value : !tick ? counter_out : !uf ? counter_out - 1'b1 : auto_reload ? reload : '0;
  end
  always_comb busy = state == RUN;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      counter_out     <= '0;
      reload          <= '0;
      underflow_out   <= 1'b0;
      underflow_pulse <= 1'b0;
    end else begin
      counter_out     <= count_next;
      reload          <= load ? load_value : reload;
      underflow_out   <= uf || (underflow_out && !underflow_clr);
      underflow_pulse <= uf;
    end
endmodule

// File: tb/tb_first_down_counter.sv
// tb_first_down_counter: table-driven and directed self-check of first_down_counter
module tb_first_down_counter;
  logic clk = 1'b0, reset = 1'b0, load = 1'b0, enable = 1'b0, auto_reload = 1'b0, underflow_clr = 1'b0;
  logic [3:0] load_value = '0, counter_out;
  logic underflow_out, underflow_pulse, busy;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic ld; logic [3:0] lv; logic en, ar, clr;
    logic [3:0] cnt; logic flag, pulse, bsy;
  } vec_t;
  vec_t vecs[$];
  first_down_counter #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .enable(enable),
    .auto_reload(auto_reload), .underflow_clr(underflow_clr), .counter_out(counter_out),
    .underflow_out(underflow_out), .underflow_pulse(underflow_pulse), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input logic [3:0] c, input logic f, input logic p, input logic b);
    check({tag, " counter_out"}, int'(counter_out), int'(c));
    check({tag, " underflow_out"}, int'(underflow_out), int'(f));
    check({tag, " underflow_pulse"}, int'(underflow_pulse), int'(p));
    check({tag, " busy"}, int'(busy), int'(b));
  endtask
  task automatic add(input logic ld, input logic [3:0] lv, input logic en, input logic ar, input logic clr,
                     input logic [3:0] c, input logic f, input logic p, input logic b);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.ar = ar; v.clr = clr;
    v.cnt = c; v.flag = f; v.pulse = p; v.bsy = b;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic ld, input logic [3:0] lv, input logic en, input logic ar, input logic clr);
    load = ld; load_value = lv; enable = en; auto_reload = ar; underflow_clr = clr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
`ifndef FIRST_DOWN_COUNTER_PRESCALE_EN
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 3, 0, 0, 1);
    add(0, 0, 1, 0, 0, 2, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 2, 1, 1, 0, 2, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 2, 1, 1, 1);
    add(0, 0, 1, 1, 0, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 1, 0, 2, 1, 1, 1);
    add(0, 0, 1, 1, 0, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 1, 0, 2, 1, 1, 1);
    add(1, 5, 1, 1, 0, 5, 1, 0, 1);
    add(0, 0, 1, 1, 0, 4, 1, 0, 1);
    add(0, 0, 0, 1, 0, 4, 1, 0, 1);
    add(0, 0, 0, 1, 0, 4, 1, 0, 1);
    add(0, 0, 0, 1, 0, 4, 1, 0, 1);
    add(1, 9, 1, 1, 0, 9, 1, 0, 1);
    add(0, 0, 1, 1, 0, 8, 1, 0, 1);
    add(0, 0, 0, 1, 1, 8, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].flag, vecs[i].pulse, vecs[i].bsy);
    end
    drive(1, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    check_all("pre_reset_uf", 4'd0, 1'b1, 1'b1, 1'b1);
    drive(1, 5, 0, 1, 0);
    check_all("pre_reset_run", 4'd5, 1'b1, 1'b0, 1'b1);
`else
    begin
      int n = 0;
      drive(1, 1, 1, 0, 0);
      while (!underflow_pulse && n < 40) begin drive(0, 0, 1, 0, 0); n++; end
      check("prescale_latency", n, 8);
      n = 0;
      drive(1, 1, 1, 0, 1);
      for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 0, 0); n++; end
      for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 0, 0); n++; end
      while (!underflow_pulse && n < 40) begin drive(0, 0, 1, 0, 0); n++; end
      check("prescale_paused_latency", n, 10);
    end
    drive(1, 5, 0, 1, 0);
`endif
    #3;
    reset = 1'b0;
    #1;
    check_all("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 7, 1, 0, 0);
    drive(0, 7, 1, 0, 0);
    check_all("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1, 6, 0, 0, 0);
    check_all("load_after_reset", 4'd6, 1'b0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/first_down_counter.md
Name: first_down_counter

Overview:
- Loadable down-counter/timer with underflow detection; the counting-down counterpart of the team's 4-bit up-counter with overflow.
- Software or a sequencer loads a start value, and the block counts down while enabled.
- On underflow it flags the event, then either stops or auto-reloads.
- Used as an interval timer and watchdog beside the up-counter in the same clock domain.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- PRESCALE, 4, count-tick divider; used only when FIRST_DOWN_COUNTER_PRESCALE_EN is defined (legal range 2..256).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  load request; loads load_value and starts counting.
- load_value  input  WIDTH  start/reload value, captured when load=1.
- enable  input  1  count enable; counting pauses while low.
- auto_reload  input  1  1 = reload on underflow and keep running; 0 = stop in DONE.
- underflow_clr  input  1  clears the sticky underflow_out.
- counter_out  output  WIDTH  current count.
- underflow_out  output  1  sticky underflow flag.
- underflow_pulse  output  1  one-cycle strobe on each underflow event.
- busy  output  1  high while in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low. While reset=0:
  - all state returns to IDLE;
  - counter_out=0, reload register=0, underflow_out=0, underflow_pulse=0, busy=0;
  - prescale counter=0.
- All outputs are registered. busy=1 exactly when state=RUN.
- States:
  - IDLE: waits for load.
  - RUN: counts on each tick.
  - DONE: underflowed with auto_reload=0; holds counter_out=0 and ignores enable.
- Load, any state:
  - counter_out<=load_value and reload register<=load_value; next state RUN.
  - underflow_pulse=0 that cycle.
  - load has priority over a coincident tick.
- tick:
  - macro undefined: tick = enable, with state RUN and no load.
  - macro defined: see Optional Feature.
- Tick in RUN with counter_out!=0: counter_out<=counter_out-1, modulo 2^WIDTH arithmetic; no other effect.
- Tick in RUN with counter_out==0 is the underflow event:
  - underflow_pulse=1 for the next cycle only; underflow_out<=1.
  - auto_reload=1: counter_out<=reload register; stay in RUN.
  - auto_reload=0: counter_out stays 0; go to DONE (busy=0).
- Latency: load value N with enable held high produces the underflow event on tick N+1, i.e. N+1 ticks after load.
- load_value=0: underflow occurs on the first tick.
- underflow_clr clears underflow_out. If an underflow event and underflow_clr occur in the same cycle, the set wins.
- enable low in RUN: counter_out and the prescale counter hold; busy stays 1.
- auto_reload is sampled at the underflow cycle only.
- Reset asserted mid-count: immediate return to IDLE, with the values listed under Clock and reset.

Optional Feature:
- Macro: FIRST_DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - A prescale counter of width clog2(PRESCALE) increments while enable=1 in RUN.
  - tick asserts when the prescale counter equals PRESCALE-1, and the prescale counter wraps to 0 on that cycle.
  - The prescale counter clears on load and in IDLE/DONE, and holds when enable=0.
  - Load value N therefore underflows after (N+1)*PRESCALE enabled cycles.
- Undefined:
  - No prescale logic; tick = enable in RUN.
  - The PRESCALE parameter is unused.

Decomposition:
- Shared package first_counter_pkg holds:
  - the state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH constant, shared with the up-counter.
- One sub-module: first_prescaler (produces tick from enable/clear). It is instantiated only under the macro.
- The FSM and counter datapath stay in first_down_counter.

Test Plan:
- Reset: drive reset=0 mid-RUN with counter_out=5 → immediately counter_out=0, busy=0, underflow_out=0, all flags 0; stays IDLE after reset=1 until load.
- One-shot: load_value=3, auto_reload=0, enable=1 → counter_out 3,2,1,0; underflow_pulse on the 4th tick; then DONE with counter_out=0, busy=0, underflow_out=1.
- Auto-reload: load_value=2, auto_reload=1, enable=1 for 9 cycles → sequence 2,1,0,2,1,0,2,1,0; a pulse every 3rd tick; busy stays 1.
- Pause and load priority:
  - enable=0 for 3 cycles at counter_out=4 → holds 4.
  - load(9) coincident with a tick → counter_out=9 with no decrement.
- Sticky clear race: underflow_clr=1 in the same cycle as an underflow → underflow_out=1; underflow_clr alone on the next cycle → 0.
- Prescale (macro defined, PRESCALE=4): load_value=1, enable=1 → underflow_pulse 8 cycles after load; dropping enable for 2 cycles mid-count delays the pulse by exactly 2 cycles.
